// File: rtl/stream_demux_1x2_if.sv
// Handshake bundle for stream_demux_1x2: one input stream and two output streams.
// master: the environment (drives the input word, consumes both outputs).
// slave:  the demultiplexer itself.
interface stream_demux_1x2_if #(
    parameter int unsigned Datawidth = 32
) ();

    // Input stream
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_sel;
    logic [Datawidth-1:0] in_data;

    // Output stream 0
    logic                 out0_valid;
    logic                 out0_ready;
    logic [Datawidth-1:0] out0_data;

    // Output stream 1
    logic                 out1_valid;
    logic                 out1_ready;
    logic [Datawidth-1:0] out1_data;

    modport master (
        output in_valid,
        output in_sel,
        output in_data,
        output out0_ready,
        output out1_ready,
        input  in_ready,
        input  out0_valid,
        input  out0_data,
        input  out1_valid,
        input  out1_data
    );

    modport slave (
        input  in_valid,
        input  in_sel,
        input  in_data,
        input  out0_ready,
        input  out1_ready,
        output in_ready,
        output out0_valid,
        output out0_data,
        output out1_valid,
        output out1_data
    );

endinterface

// File: rtl/stream_demux_1x2.sv
// Registered 1-to-2 stream demultiplexer.
// Each accepted input word goes to output 0 or 1 according to in_sel. Every output owns a
// one-entry register slice, so an accepted word appears on its output one cycle later and a
// stalled consumer only blocks words addressed to it.
// Optional feature: define DEMUX_COUNT_EN to add per-output drain counters cnt0/cnt1.
module stream_demux_1x2 #(
    parameter int unsigned Datawidth  = 32,
    parameter int unsigned CountWidth = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    stream_demux_1x2_if.slave     dmx_io
`ifdef DEMUX_COUNT_EN
    ,
    output logic [CountWidth-1:0] cnt0,
    output logic [CountWidth-1:0] cnt1
`endif
);

    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } slot_state_e;

    slot_state_e          st0_q, st0_d;
    slot_state_e          st1_q, st1_d;
    logic [Datawidth-1:0] data0_q, data0_d;
    logic [Datawidth-1:0] data1_q, data1_d;

    logic in_ready;
    logic accept;
    logic load0, load1;
    logic drain0, drain1;

    // Input side: a slice can take a word when empty or when it is being drained this cycle.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            if (dmx_io.in_sel) begin
                in_ready = (st1_q == StEmpty) || dmx_io.out1_ready;
            end else begin
                in_ready = (st0_q == StEmpty) || dmx_io.out0_ready;
            end
        end
    end

    // Per-slot load and drain strobes.
    always_comb begin
        accept = dmx_io.in_valid & in_ready;
        load0  = accept & ~dmx_io.in_sel;
        load1  = accept &  dmx_io.in_sel;
        drain0 = (st0_q == StFull) & dmx_io.out0_ready;
        drain1 = (st1_q == StFull) & dmx_io.out1_ready;
    end

    // Slot 0 next state: load wins over drain so a simultaneous drain+load stays full.
    always_comb begin
        st0_d   = st0_q;
        data0_d = data0_q;
        unique case (st0_q)
            StEmpty: begin
                if (load0) begin
                    st0_d   = StFull;
                    data0_d = dmx_io.in_data;
                end
            end
            StFull: begin
                if (load0) begin
                    st0_d   = StFull;
                    data0_d = dmx_io.in_data;
                end else if (drain0) begin
                    st0_d = StEmpty;
                end
            end
            default: begin
                st0_d = StEmpty;
            end
        endcase
    end

    // Slot 1 next state: mirror of slot 0.
    always_comb begin
        st1_d   = st1_q;
        data1_d = data1_q;
        unique case (st1_q)
            StEmpty: begin
                if (load1) begin
                    st1_d   = StFull;
                    data1_d = dmx_io.in_data;
                end
            end
            StFull: begin
                if (load1) begin
                    st1_d   = StFull;
                    data1_d = dmx_io.in_data;
                end else if (drain1) begin
                    st1_d = StEmpty;
                end
            end
            default: begin
                st1_d = StEmpty;
            end
        endcase
    end

    // Slice registers; reset discards any held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            st0_q   <= StEmpty;
            st1_q   <= StEmpty;
            data0_q <= '0;
            data1_q <= '0;
        end else begin
            st0_q   <= st0_d;
            st1_q   <= st1_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
        end
    end

    // Outputs come straight from the slices: no combinational path from input data.
    always_comb begin
        dmx_io.in_ready   = in_ready;
        dmx_io.out0_valid = (st0_q == StFull);
        dmx_io.out0_data  = data0_q;
        dmx_io.out1_valid = (st1_q == StFull);
        dmx_io.out1_data  = data1_q;
    end

`ifdef DEMUX_COUNT_EN
    logic [CountWidth-1:0] cnt0_q, cnt0_d;
    logic [CountWidth-1:0] cnt1_q, cnt1_d;

    // Drain counters wrap naturally at 2^CountWidth.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (drain0) begin
            cnt0_d = cnt0_q + 1'b1;
        end
        if (drain1) begin
            cnt1_d = cnt1_q + 1'b1;
        end
    end

    // Counter registers; reset wins over any drain seen in the reset cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    // Counter outputs.
    always_comb begin
        cnt0 = cnt0_q;
        cnt1 = cnt1_q;
    end
`endif

endmodule

// File: tb/tb_stream_demux_1x2.sv
// Directed bench for stream_demux_1x2: a vector table covering reset, routing, hold,
// back-pressure isolation and simultaneous load/drain, followed by hand-written streaming,
// mid-operation reset and (with DEMUX_COUNT_EN) counter-wrap sequences.
module tb_stream_demux_1x2;

    localparam int unsigned Dw = 32;
    localparam int unsigned Cw = 4;

    logic clk;
    logic rst;

    stream_demux_1x2_if #(.Datawidth(Dw)) dmx ();

`ifdef DEMUX_COUNT_EN
    logic [Cw-1:0] cnt0;
    logic [Cw-1:0] cnt1;
`endif

    stream_demux_1x2 #(
        .Datawidth (Dw),
        .CountWidth(Cw)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .dmx_io(dmx.slave)
`ifdef DEMUX_COUNT_EN
        ,
        .cnt0  (cnt0),
        .cnt1  (cnt1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        iv;
        logic        sel;
        logic [31:0] data;
        logic        r0;
        logic        r1;
        logic        ir;
        logic        v0;
        logic [31:0] d0;
        logic        v1;
        logic [31:0] d1;
        int unsigned c0;
        int unsigned c1;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;
    vec_t tbl[19];

    function automatic vec_t mk(input logic r, input logic iv, input logic sel,
                                input logic [31:0] data, input logic r0, input logic r1,
                                input logic ir, input logic v0, input logic [31:0] d0,
                                input logic v1, input logic [31:0] d1,
                                input int unsigned c0, input int unsigned c1);
        vec_t v;
        v.rst = r; v.iv = iv; v.sel = sel; v.data = data; v.r0 = r0; v.r1 = r1;
        v.ir = ir; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.c0 = c0; v.c1 = c1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic sel, input logic [31:0] data,
                         input logic r0, input logic r1);
        rst             = r;
        dmx.in_valid    = iv;
        dmx.in_sel      = sel;
        dmx.in_data     = data;
        dmx.out0_ready  = r0;
        dmx.out1_ready  = r1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Columns: rst iv sel data r0 r1 | in_ready v0 d0 v1 d1 cnt0 cnt1 (values before the edge)
        tbl[0]  = mk(1, 1, 1, 32'hDEADBEEF, 1, 1,  0, 0, 32'h0, 0, 32'h0,        0, 0);
        tbl[1]  = mk(0, 1, 1, 32'hDEADBEEF, 0, 0,  1, 0, 32'h0, 0, 32'h0,        0, 0);
        tbl[2]  = mk(0, 0, 1, 32'h00000000, 0, 0,  0, 0, 32'h0, 1, 32'hDEADBEEF, 0, 0);
        tbl[3]  = mk(0, 0, 0, 32'hFFFFFFFF, 0, 0,  1, 0, 32'h0, 1, 32'hDEADBEEF, 0, 0);
        tbl[4]  = mk(0, 0, 1, 32'h12345678, 0, 0,  0, 0, 32'h0, 1, 32'hDEADBEEF, 0, 0);
        tbl[5]  = mk(0, 0, 1, 32'h00000000, 0, 0,  0, 0, 32'h0, 1, 32'hDEADBEEF, 0, 0);
        tbl[6]  = mk(0, 0, 1, 32'h00000000, 0, 1,  1, 0, 32'h0, 1, 32'hDEADBEEF, 0, 0);
        tbl[7]  = mk(0, 1, 1, 32'hCAFE0001, 0, 0,  1, 0, 32'h0, 0, 32'hDEADBEEF, 0, 1);
        tbl[8]  = mk(0, 1, 1, 32'hBAD00000, 0, 0,  0, 0, 32'h0, 1, 32'hCAFE0001, 0, 1);
        tbl[9]  = mk(0, 1, 0, 32'h00000001, 0, 0,  1, 0, 32'h0, 1, 32'hCAFE0001, 0, 1);
        tbl[10] = mk(0, 0, 0, 32'h00000000, 0, 0,  0, 1, 32'h1, 1, 32'hCAFE0001, 0, 1);
        tbl[11] = mk(0, 1, 1, 32'h0000005A, 0, 1,  1, 1, 32'h1, 1, 32'hCAFE0001, 0, 1);
        tbl[12] = mk(0, 1, 0, 32'h000000A5, 1, 0,  1, 1, 32'h1, 1, 32'h5A,       0, 2);
        tbl[13] = mk(0, 1, 1, 32'h00000077, 1, 0,  0, 1, 32'hA5, 1, 32'h5A,      1, 2);
        tbl[14] = mk(0, 1, 0, 32'h000000B0, 0, 1,  1, 0, 32'hA5, 1, 32'h5A,      2, 2);
        tbl[15] = mk(0, 0, 0, 32'h00000000, 0, 0,  0, 1, 32'hB0, 0, 32'h5A,      2, 3);
        tbl[16] = mk(0, 1, 1, 32'h000000C1, 0, 0,  1, 1, 32'hB0, 0, 32'h5A,      2, 3);
        tbl[17] = mk(1, 1, 0, 32'h000000EE, 1, 1,  0, 1, 32'hB0, 1, 32'hC1,      2, 3);
        tbl[18] = mk(0, 0, 0, 32'h00000000, 1, 1,  1, 0, 32'h0, 0, 32'h0,        0, 0);

        // First reset cycle: state is unknown before it, so only in_ready is checked.
        drive(1, 1, 0, 32'h0, 0, 0);
        #1;
        check("pre-reset in_ready", {31'b0, dmx.in_ready}, 32'h0);
        tick();

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].rst, tbl[i].iv, tbl[i].sel, tbl[i].data, tbl[i].r0, tbl[i].r1);
            #1;
            check($sformatf("row%0d in_ready", i), {31'b0, dmx.in_ready}, {31'b0, tbl[i].ir});
            check($sformatf("row%0d out0_valid", i), {31'b0, dmx.out0_valid}, {31'b0, tbl[i].v0});
            check($sformatf("row%0d out0_data", i), dmx.out0_data, tbl[i].d0);
            check($sformatf("row%0d out1_valid", i), {31'b0, dmx.out1_valid}, {31'b0, tbl[i].v1});
            check($sformatf("row%0d out1_data", i), dmx.out1_data, tbl[i].d1);
`ifdef DEMUX_COUNT_EN
            check($sformatf("row%0d cnt0", i), {28'b0, cnt0}, tbl[i].c0);
            check($sformatf("row%0d cnt1", i), {28'b0, cnt1}, tbl[i].c1);
`endif
            tick();
        end

        // Streaming: 8 words to out0 with its ready held high; one word per cycle.
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 0, i, 1, 0);
            #1;
            check($sformatf("stream%0d in_ready", i), {31'b0, dmx.in_ready}, 32'h1);
            if (i > 0) begin
                check($sformatf("stream%0d out0_valid", i), {31'b0, dmx.out0_valid}, 32'h1);
                check($sformatf("stream%0d out0_data", i), dmx.out0_data, i - 1);
            end
            check($sformatf("stream%0d out1_valid", i), {31'b0, dmx.out1_valid}, 32'h0);
            tick();
        end
        drive(0, 0, 0, 32'h0, 1, 0);
        #1;
        check("stream tail out0_valid", {31'b0, dmx.out0_valid}, 32'h1);
        check("stream tail out0_data", dmx.out0_data, 32'h7);
        tick();
        check("stream drained out0_valid", {31'b0, dmx.out0_valid}, 32'h0);
`ifdef DEMUX_COUNT_EN
        check("stream cnt0", {28'b0, cnt0}, 32'd8);
        check("stream cnt1", {28'b0, cnt1}, 32'd0);
`endif

        // Reset with both slices full and both consumers ready: nothing is delivered.
        drive(0, 1, 0, 32'h11, 0, 0);
        tick();
        drive(0, 1, 1, 32'h22, 0, 0);
        tick();
        drive(0, 0, 0, 32'h0, 0, 0);
        #1;
        check("midrst pre out0_data", dmx.out0_data, 32'h11);
        check("midrst pre out1_data", dmx.out1_data, 32'h22);
        drive(1, 0, 0, 32'h0, 1, 1);
        tick();
        drive(0, 0, 0, 32'h0, 1, 1);
        #1;
        check("midrst out0_valid", {31'b0, dmx.out0_valid}, 32'h0);
        check("midrst out1_valid", {31'b0, dmx.out1_valid}, 32'h0);
        check("midrst out0_data", dmx.out0_data, 32'h0);
        check("midrst out1_data", dmx.out1_data, 32'h0);
`ifdef DEMUX_COUNT_EN
        check("midrst cnt0", {28'b0, cnt0}, 32'd0);
        check("midrst cnt1", {28'b0, cnt1}, 32'd0);

        // 17 drains on out0 with a 4-bit counter wrap to 1.
        for (int i = 0; i < 17; i++) begin
            drive(0, 1, 0, 32'h100 + i, 1, 1);
            tick();
        end
        drive(0, 0, 0, 32'h0, 1, 1);
        tick();
        check("wrap cnt0", {28'b0, cnt0}, 32'd1);
        check("wrap cnt1", {28'b0, cnt1}, 32'd0);
        check("wrap out0_valid", {31'b0, dmx.out0_valid}, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
